lock_sequencer: RTL and testbench

Synchronous sequencer for the lock's password datapath. It takes the store, input and submit buttons and the digit switches, and issues one-cycle writes into a two-bank digit register file (input bank and system bank). It runs a serial digit-by-digit compare, counts failed attempts, enforces a timed lockout and drives the unlock indication. It sits between the debounced button inputs and the register file and HEX/LED display logic, replacing the level-triggered multi-edge control of the existing checker.

---
 rtl/lock_pkg.sv | 23 ++
 rtl/lock_sequencer_if.sv | 25 ++
 rtl/lock_sequencer_btn_rise.sv | 18 +
 rtl/lock_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared state codes, bank selects and default sizing for the lock sequencer.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        STORE   = 3'd2,
        COMPARE = 3'd3,
        UNLOCK  = 3'd4,
        FAIL    = 3'd5,
        LOCKOUT = 3'd6
    } lock_state_t;

    localparam logic BANK_IN  = 1'b0;
    localparam logic BANK_SYS = 1'b1;

    localparam int DEF_PW_LEN         = 4;
    localparam int DEF_DIGIT_W        = 2;
    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int DEF_UNLOCK_CYCLES  = 8;

endpackage

// File: rtl/lock_sequencer_if.sv
// Register file bus between the sequencer (master) and the two digit banks (slave).
interface lock_sequencer_if #(
    parameter int PW_LEN  = 4,
    parameter int DIGIT_W = 2
) ();
    localparam int AW = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;

    logic               wr_en;
    logic               wr_bank;
    logic [AW-1:0]      wr_addr;
    logic [DIGIT_W-1:0] wr_data;
    logic [AW-1:0]      rd_addr;
    logic [DIGIT_W-1:0] in_rd_data;
    logic [DIGIT_W-1:0] sys_rd_data;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data, rd_addr,
        input  in_rd_data, sys_rd_data
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data, rd_addr,
        output in_rd_data, sys_rd_data
    );
endinterface

// File: rtl/lock_sequencer_btn_rise.sv
// One-flop rising-edge detector. Reset preloads the current level so a
// button held through reset does not produce an edge afterwards.
module btn_rise (
    input  logic clk,
    input  logic system_reset,
    input  logic btn,
    output logic rise
);
    logic prev_reg;

    // Track the previous level; reset loads the live level rather than 0.
    always_ff @(posedge clk) begin
        if (system_reset) prev_reg <= btn;
        else              prev_reg <= btn;
    end

    assign rise = btn & ~prev_reg;
endmodule

// File: rtl/lock_sequencer.sv
// Password sequencer: digit entry/store writes, serial compare, attempt
// counting, timed lockout and timed unlock indication.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int PW_LEN         = DEF_PW_LEN,
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES
) (
    input  logic                              clk,
    input  logic                              system_reset,
    input  logic                              store_btn,
    input  logic                              input_btn,
    input  logic                              submit_btn,
    input  logic [DIGIT_W-1:0]                digit,
    lock_sequencer_if.master                  rf,
    output logic                              unlock,
    output logic                              locked_out,
    output logic [2:0]                        state,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts,
    output logic [$clog2(PW_LEN+1)-1:0]       in_count,
    output logic [$clog2(PW_LEN+1)-1:0]       pw_len,
    output logic                              pw_valid
);
    localparam int AW   = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
    localparam int CW   = $clog2(PW_LEN+1);
    localparam int ATW  = $clog2(MAX_ATTEMPTS+1);
    localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // Button order in the vector: 0 = store, 1 = input, 2 = submit.
    logic [2:0] btn_vec;
    logic [2:0] rise_vec;
    logic       store_rise, input_rise, submit_rise;

    assign btn_vec = {submit_btn, input_btn, store_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rise
            btn_rise u_rise (
                .clk          (clk),
                .system_reset (system_reset),
                .btn          (btn_vec[gi]),
                .rise         (rise_vec[gi])
            );
        end
    endgenerate

    assign store_rise  = rise_vec[0];
    assign input_rise  = rise_vec[1];
    assign submit_rise = rise_vec[2];

    lock_state_t        state_reg, state_next;
    logic [AW-1:0]      idx_reg, idx_next;
    logic               mismatch_reg, mismatch_next, mismatch_now;
    logic [CW-1:0]      in_count_reg, in_count_next;
    logic [CW-1:0]      store_cnt_reg, store_cnt_next;
    logic [CW-1:0]      pw_len_reg, pw_len_next;
    logic               pw_valid_reg, pw_valid_next;
    logic [ATW-1:0]     attempts_reg, attempts_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic               wr_en_reg, wr_en_next;
    logic               wr_bank_reg, wr_bank_next;
    logic [AW-1:0]      wr_addr_reg, wr_addr_next;
    logic [DIGIT_W-1:0] wr_data_reg, wr_data_next;
    logic               unlock_reg, locked_out_reg;

    // Next-state, counters, timer and write strobe generation.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        mismatch_next  = mismatch_reg;
        in_count_next  = in_count_reg;
        store_cnt_next = store_cnt_reg;
        pw_len_next    = pw_len_reg;
        pw_valid_next  = pw_valid_reg;
        attempts_next  = attempts_reg;
        timer_next     = timer_reg;
        wr_en_next     = 1'b0;
        wr_bank_next   = wr_bank_reg;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        // Digits beyond the stored length do not take part in the compare.
        mismatch_now   = mismatch_reg |
                         ((CW'(idx_reg) < pw_len_reg) && (rf.in_rd_data != rf.sys_rd_data));

        case (state_reg)
            IDLE: begin
                if (input_rise) begin
                    wr_en_next    = 1'b1;
                    wr_bank_next  = BANK_IN;
                    wr_addr_next  = '0;
                    wr_data_next  = digit;
                    in_count_next = CW'(1);
                    state_next    = ENTER;
                end else if (store_rise) begin
                    wr_en_next     = 1'b1;
                    wr_bank_next   = BANK_SYS;
                    wr_addr_next   = '0;
                    wr_data_next   = digit;
                    store_cnt_next = CW'(1);
                    state_next     = STORE;
                end
            end
            ENTER: begin
                if (submit_rise) begin
                    idx_next      = '0;
                    mismatch_next = 1'b0;
                    state_next    = COMPARE;
                end else if (input_rise && (in_count_reg < CW'(PW_LEN))) begin
                    wr_en_next    = 1'b1;
                    wr_bank_next  = BANK_IN;
                    wr_addr_next  = AW'(in_count_reg);
                    wr_data_next  = digit;
                    in_count_next = in_count_reg + 1'b1;
                end
            end
            STORE: begin
                if (submit_rise) begin
                    pw_len_next   = store_cnt_reg;
                    pw_valid_next = 1'b1;
                    state_next    = IDLE;
                end else if (store_rise && (store_cnt_reg < CW'(PW_LEN))) begin
                    wr_en_next     = 1'b1;
                    wr_bank_next   = BANK_SYS;
                    wr_addr_next   = AW'(store_cnt_reg);
                    wr_data_next   = digit;
                    store_cnt_next = store_cnt_reg + 1'b1;
                end
            end
            COMPARE: begin
                mismatch_next = mismatch_now;
                idx_next      = idx_reg + 1'b1;
                if (idx_reg == AW'(PW_LEN-1)) begin
                    in_count_next = '0;
                    if (pw_valid_reg && !mismatch_now && (in_count_reg == pw_len_reg)) begin
                        attempts_next = '0;
                        timer_next    = TW'(UNLOCK_CYCLES-1);
                        state_next    = UNLOCK;
                    end else begin
                        state_next    = FAIL;
                    end
                end
            end
            UNLOCK: begin
                if (timer_reg == '0) state_next = IDLE;
                else                 timer_next = timer_reg - 1'b1;
            end
            FAIL: begin
                in_count_next = '0;
                if ((attempts_reg + 1'b1) == ATW'(MAX_ATTEMPTS)) begin
                    attempts_next = ATW'(MAX_ATTEMPTS);
                    timer_next    = TW'(LOCKOUT_CYCLES-1);
                    state_next    = LOCKOUT;
                end else begin
                    attempts_next = attempts_reg + 1'b1;
                    state_next    = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_reg == '0) begin
                    attempts_next = '0;
                    state_next    = IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk) begin
        if (system_reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            mismatch_reg   <= 1'b0;
            in_count_reg   <= '0;
            store_cnt_reg  <= '0;
            pw_len_reg     <= '0;
            pw_valid_reg   <= 1'b0;
            attempts_reg   <= '0;
            timer_reg      <= '0;
            wr_en_reg      <= 1'b0;
            wr_bank_reg    <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            unlock_reg     <= 1'b0;
            locked_out_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            mismatch_reg   <= mismatch_next;
            in_count_reg   <= in_count_next;
            store_cnt_reg  <= store_cnt_next;
            pw_len_reg     <= pw_len_next;
            pw_valid_reg   <= pw_valid_next;
            attempts_reg   <= attempts_next;
            timer_reg      <= timer_next;
            wr_en_reg      <= wr_en_next;
            wr_bank_reg    <= wr_bank_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            unlock_reg     <= (state_next == UNLOCK);
            locked_out_reg <= (state_next == LOCKOUT);
        end
    end

    assign rf.wr_en   = wr_en_reg;
    assign rf.wr_bank = wr_bank_reg;
    assign rf.wr_addr = wr_addr_reg;
    assign rf.wr_data = wr_data_reg;
    assign rf.rd_addr = idx_reg;

    assign unlock     = unlock_reg;
    assign locked_out = locked_out_reg;
    assign state      = state_reg;
    assign attempts   = attempts_reg;
    assign in_count   = in_count_reg;
    assign pw_len     = pw_len_reg;
    assign pw_valid   = pw_valid_reg;
endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a behavioural two-bank register file.
module tb_lock_sequencer;
    logic       clk = 1'b0;
    logic       system_reset;
    logic       store_btn, input_btn, submit_btn;
    logic [1:0] digit;
    logic       unlock, locked_out, pw_valid;
    logic [2:0] state;
    logic [1:0] attempts;
    logic [2:0] in_count, pw_len;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lock_sequencer_if #(.PW_LEN(4), .DIGIT_W(2)) rf ();

    lock_sequencer #(
        .PW_LEN(4), .DIGIT_W(2), .MAX_ATTEMPTS(3),
        .LOCKOUT_CYCLES(16), .UNLOCK_CYCLES(8)
    ) dut (
        .clk          (clk),
        .system_reset (system_reset),
        .store_btn    (store_btn),
        .input_btn    (input_btn),
        .submit_btn   (submit_btn),
        .digit        (digit),
        .rf           (rf),
        .unlock       (unlock),
        .locked_out   (locked_out),
        .state        (state),
        .attempts     (attempts),
        .in_count     (in_count),
        .pw_len       (pw_len),
        .pw_valid     (pw_valid)
    );

    // Register file model: synchronous write, combinational read.
    logic [1:0] in_bank  [4];
    logic [1:0] sys_bank [4];
    always @(posedge clk) begin
        if (rf.wr_en) begin
            if (rf.wr_bank) sys_bank[rf.wr_addr] <= rf.wr_data;
            else            in_bank[rf.wr_addr]  <= rf.wr_data;
        end
    end
    assign rf.in_rd_data  = in_bank[rf.rd_addr];
    assign rf.sys_rd_data = sys_bank[rf.rd_addr];

    typedef struct {
        logic       st, in, sb;
        logic [1:0] dg;
        logic       we, bank;
        logic [1:0] addr, data;
        logic [2:0] stt;
        logic       unl;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic in, input logic sb, input logic [1:0] dg,
                                input logic we, input logic bank, input logic [1:0] addr,
                                input logic [1:0] data, input logic [2:0] stt, input logic unl,
                                input logic [2:0] cnt);
        vec_t v;
        v.st = st; v.in = in; v.sb = sb; v.dg = dg;
        v.we = we; v.bank = bank; v.addr = addr; v.data = data;
        v.stt = stt; v.unl = unl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_in(input logic [1:0] d, output logic we, output logic [1:0] a);
        input_btn = 1'b1;
        digit     = d;
        tick();
        we = rf.wr_en;
        a  = rf.wr_addr;
        $display("press input digit=%0d wr_en=%0d wr_addr=%0d in_count=%0d", d, we, a, in_count);
        input_btn = 1'b0;
        tick();
    endtask

    task automatic enter_n(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                           input logic [1:0] d3, input int n);
        logic [1:0] ds [4];
        logic       we;
        logic [1:0] a;
        ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
        for (int i = 0; i < n; i++) press_in(ds[i], we, a);
    endtask

    // Submit rise, then wait (bounded) for the compare to finish.
    task automatic do_submit(output logic [2:0] res);
        int k;
        submit_btn = 1'b1;
        tick();
        submit_btn = 1'b0;
        chk("submit_to_compare", state, 3);
        k = 0;
        while (state == 3'd3 && k < 12) begin
            tick();
            k++;
        end
        chk("compare_cycles", k, 4);
        res = state;
        $display("submit done: state=%0d attempts=%0d", state, attempts);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_unlock"}, unlock, 0);
        chk({tag, "_locked_out"}, locked_out, 0);
        chk({tag, "_wr_en"}, rf.wr_en, 0);
        chk({tag, "_wr_bank"}, rf.wr_bank, 0);
        chk({tag, "_wr_addr"}, rf.wr_addr, 0);
        chk({tag, "_wr_data"}, rf.wr_data, 0);
        chk({tag, "_rd_addr"}, rf.rd_addr, 0);
        chk({tag, "_attempts"}, attempts, 0);
        chk({tag, "_in_count"}, in_count, 0);
        chk({tag, "_pw_len"}, pw_len, 0);
        chk({tag, "_pw_valid"}, pw_valid, 0);
    endtask

    initial begin
        logic [2:0] res;
        logic       we;
        logic [1:0] a;
        logic [1:0] ovf_digits [6];
        int         lo_cnt, wr_seen, guard;

        system_reset = 1'b1;
        store_btn = 1'b0; input_btn = 1'b0; submit_btn = 1'b0; digit = 2'd0;
        tick();
        tick();
        chk_reset_vals("reset");
        system_reset = 1'b0;

        // Store 2,1,3,0 then enter 2,1,3,0 and expect an 8-cycle unlock.
        tbl.push_back(mk(1,0,0,2, 1,1,0,2, 2,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2,0,0));
        tbl.push_back(mk(1,0,0,1, 1,1,1,1, 2,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2,0,0));
        tbl.push_back(mk(1,0,0,3, 1,1,2,3, 2,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2,0,0));
        tbl.push_back(mk(1,0,0,0, 1,1,3,0, 2,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 2,0,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,2, 1,0,0,2, 1,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1));
        tbl.push_back(mk(0,1,0,1, 1,0,1,1, 1,0,2));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,2));
        tbl.push_back(mk(0,1,0,3, 1,0,2,3, 1,0,3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,3));
        tbl.push_back(mk(0,1,0,0, 1,0,3,0, 1,0,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,4));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0, 3,0,4));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0, 0,0,0,0, 3,0,4));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,0,0, 0,0,0,0, 4,1,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0));

        foreach (tbl[i]) begin
            store_btn  = tbl[i].st;
            input_btn  = tbl[i].in;
            submit_btn = tbl[i].sb;
            digit      = tbl[i].dg;
            tick();
            $display("vec %0d: st=%0d in=%0d sb=%0d dg=%0d -> state=%0d wr_en=%0d bank=%0d addr=%0d data=%0d unlock=%0d in_count=%0d",
                     i, tbl[i].st, tbl[i].in, tbl[i].sb, tbl[i].dg, state, rf.wr_en,
                     rf.wr_bank, rf.wr_addr, rf.wr_data, unlock, in_count);
            chk("vec_state", state, tbl[i].stt);
            chk("vec_wr_en", rf.wr_en, tbl[i].we);
            chk("vec_unlock", unlock, tbl[i].unl);
            chk("vec_in_count", in_count, tbl[i].cnt);
            if (tbl[i].we) begin
                chk("vec_wr_bank", rf.wr_bank, tbl[i].bank);
                chk("vec_wr_addr", rf.wr_addr, tbl[i].addr);
                chk("vec_wr_data", rf.wr_data, tbl[i].data);
            end
        end
        store_btn = 1'b0; input_btn = 1'b0; submit_btn = 1'b0;
        chk("pw_len_after_store", pw_len, 4);
        chk("pw_valid_after_store", pw_valid, 1);
        chk("attempts_after_unlock", attempts, 0);

        // Three wrong entries: 2,1,3,1 against 2,1,3,0.
        for (int t = 1; t <= 3; t++) begin
            enter_n(2, 1, 3, 1, 4);
            do_submit(res);
            chk("wrong_goes_fail", res, 5);
            tick();
            if (t < 3) begin
                chk("wrong_back_idle", state, 0);
                chk("wrong_attempts", attempts, t);
            end else begin
                chk("lockout_entered", state, 6);
                chk("lockout_attempts", attempts, 3);
                lo_cnt = 0; wr_seen = 0; guard = 0;
                while (locked_out && guard < 40) begin
                    lo_cnt++;
                    input_btn = ~input_btn;
                    store_btn = ~store_btn;
                    tick();
                    if (rf.wr_en) wr_seen++;
                    guard++;
                end
                input_btn = 1'b0; store_btn = 1'b0;
                $display("lockout: high_cycles=%0d writes_seen=%0d", lo_cnt, wr_seen);
                chk("lockout_cycles", lo_cnt, 16);
                chk("lockout_no_write", wr_seen, 0);
                chk("lockout_exit_state", state, 0);
                chk("lockout_exit_attempts", attempts, 0);
                tick();
            end
        end

        // Length mismatch: 2,1,3 against a 4-digit password.
        enter_n(2, 1, 3, 0, 3);
        do_submit(res);
        chk("short_fail", res, 5);
        tick();
        chk("short_state", state, 0);
        chk("short_attempts", attempts, 1);
        chk("short_in_count", in_count, 0);

        // Six input rises: only the first four write.
        ovf_digits[0] = 2; ovf_digits[1] = 1; ovf_digits[2] = 3;
        ovf_digits[3] = 0; ovf_digits[4] = 1; ovf_digits[5] = 1;
        for (int i = 0; i < 6; i++) begin
            press_in(ovf_digits[i], we, a);
            chk("ovf_wr_en", we, (i < 4) ? 1 : 0);
            if (i < 4) chk("ovf_wr_addr", a, i);
        end
        chk("ovf_in_count", in_count, 4);

        // Input and submit rising together: submit wins, no write.
        input_btn = 1'b1; submit_btn = 1'b1; digit = 2'd3;
        tick();
        $display("simul input+submit: state=%0d wr_en=%0d", state, rf.wr_en);
        chk("simul_state", state, 3);
        chk("simul_wr_en", rf.wr_en, 0);
        input_btn = 1'b0; submit_btn = 1'b0;
        guard = 0;
        while (state == 3'd3 && guard < 12) begin tick(); guard++; end
        chk("simul_unlock", state, 4);
        guard = 0;
        while (state != 3'd0 && guard < 20) begin tick(); guard++; end
        chk("simul_back_idle", state, 0);
        chk("simul_attempts", attempts, 0);

        // Input held through reset: no edge after release.
        input_btn = 1'b1; digit = 2'd2;
        system_reset = 1'b1;
        tick();
        system_reset = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rf.wr_en) wr_seen++;
            chk("held_state", state, 0);
        end
        $display("held through reset: writes_seen=%0d state=%0d", wr_seen, state);
        chk("held_no_write", wr_seen, 0);
        input_btn = 1'b0;
        tick();

        // No stored password since reset.
        chk("nopw_valid", pw_valid, 0);
        press_in(2'd1, we, a);
        do_submit(res);
        chk("nopw_fail", res, 5);
        tick();

        // Reset in the middle of a compare.
        press_in(2'd2, we, a);
        submit_btn = 1'b1;
        tick();
        submit_btn = 1'b0;
        chk("mid_rd_addr0", rf.rd_addr, 0);
        tick();
        chk("mid_state", state, 3);
        chk("mid_rd_addr1", rf.rd_addr, 1);
        system_reset = 1'b1;
        tick();
        $display("reset mid-compare: state=%0d attempts=%0d", state, attempts);
        chk_reset_vals("midreset");
        system_reset = 1'b0;
        tick();
        chk("post_reset_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
